// File: rtl/xnor_share_arbiter.sv
// Round-robin arbiter that time-shares one external WIDTH-bit XNOR gate among
// NREQ requesters and returns registered results over a valid/ready channel.
module xnor_share_arbiter #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      gate_a,
  output logic [WIDTH-1:0]      gate_b,
  input  logic [WIDTH-1:0]      gate_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds (with stable payload) until that edge.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_z;
  logic [CNTW-1:0] r_op_count;

  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_ready;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = wrap_add(r_ptr, k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (!rst && r_state == S_IDLE && w_found) w_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_z     <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_a   <= req_a[int'(w_grant)*WIDTH +: WIDTH];
            r_op_b   <= req_b[int'(w_grant)*WIDTH +: WIDTH];
            r_rsp_id <= w_grant;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_z     <= gate_z;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // ptr advances only here so a stalled response cannot skip anyone.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNTW'(1);
            r_ptr       <= wrap_add(r_rsp_id, 1);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign gate_a    = r_op_a;
  assign gate_b    = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_z     = r_rsp_z;
  assign busy      = (r_state != S_IDLE);
  assign op_count  = r_op_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_xnor_share_arbiter.sv
// Directed bench for xnor_share_arbiter: vector table plus hand-written
// round-robin, backpressure, mid-operation reset and counter-wrap sequences.
module tb_xnor_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready, req_ready2;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic [4:0]  gate_a, gate_b, gate_z, gate_a2, gate_b2, gate_z2;
  logic        rsp_valid, rsp_valid2;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id, rsp_id2;
  logic [4:0]  rsp_z, rsp_z2;
  logic        busy, busy2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;
  logic [1:0]  dbg_state, dbg_state2;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  // The shared external XNOR gates.
  assign gate_z  = ~(gate_a ^ gate_b);
  assign gate_z2 = ~(gate_a2 ^ gate_b2);

  xnor_share_arbiter #(.WIDTH(5), .NREQ(4), .IDW(2), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .gate_a(gate_a), .gate_b(gate_b),
    .gate_z(gate_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy), .op_count(op_count),
    .dbg_state(dbg_state)
  );

  xnor_share_arbiter #(.WIDTH(5), .NREQ(4), .IDW(2), .CNTW(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .gate_a(gate_a2), .gate_b(gate_b2),
    .gate_z(gate_z2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id2), .rsp_z(rsp_z2), .busy(busy2), .op_count(op_count2),
    .dbg_state(dbg_state2)
  );

  typedef struct {
    int         id;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] z;
  } vec_t;

  vec_t vecs[6];
  logic [4:0] rr_a[4];
  logic [4:0] rr_b[4];
  logic [4:0] rr_z[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [4:0] a, input logic [4:0] b);
    req_a[id*5 +: 5] = a;
    req_b[id*5 +: 5] = b;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.id;
    set_ops(v.id, v.a, v.b);
    req_valid = onehot;
    rsp_ready = 1'b0;
    #1;
    chk("vec_grant", 32'(req_ready), 32'(onehot));
    tick();
    chk("vec_ready_one_cycle", 32'(req_ready), 32'h0);
    chk("vec_busy", 32'(busy), 32'h1);
    chk("vec_gate_a", 32'(gate_a), 32'(v.a));
    chk("vec_gate_b", 32'(gate_b), 32'(v.b));
    chk("vec_rsp_valid_exec", 32'(rsp_valid), 32'h0);
    req_valid = '0;
    tick();
    chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
    chk("vec_rsp_z", 32'(rsp_z), 32'(v.z));
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    rsp_ready = 1'b0;
    chk("vec_rsp_done", 32'(rsp_valid), 32'h0);
    chk("vec_op_count", 32'(op_count), 32'(exp_cnt));
    chk("vec_busy_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int fires;
    logic prev_fire;
    int exp_ids[6];

    vecs[0] = '{2, 5'b10110, 5'b10011, 5'b11010};
    vecs[1] = '{0, 5'b00000, 5'b00000, 5'b11111};
    vecs[2] = '{3, 5'b01010, 5'b10101, 5'b00000};
    vecs[3] = '{1, 5'b11000, 5'b01100, 5'b01011};
    vecs[4] = '{0, 5'b01111, 5'b00111, 5'b10111};
    vecs[5] = '{3, 5'b10101, 5'b10101, 5'b11111};
    rr_a = '{5'b00001, 5'b11000, 5'b10110, 5'b10101};
    rr_b = '{5'b00011, 5'b01100, 5'b10011, 5'b10101};
    rr_z = '{5'b11101, 5'b01011, 5'b11010, 5'b11111};
    exp_ids = '{0, 1, 2, 3, 0, 1};

    // Reset held two cycles with every requester asking.
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = 20'hABCDE;
    req_b = 20'h13579;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gate_a", 32'(gate_a), 32'h0);
      chk("rst_gate_b", 32'(gate_b), 32'h0);
      chk("rst_op_count", 32'(op_count), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
    chk("idle_no_req_ready", 32'(req_ready), 32'h0);
    chk("idle_no_req_busy", 32'(busy), 32'h0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Round-robin from a fresh reset with all requesters held valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    fires = 0;
    prev_fire = 1'b0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      tick();
      if (prev_fire) exp_cnt++;
      chk("rr_wrap_count", 32'(op_count2), 32'(exp_cnt % 4));
      prev_fire = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (fires < 6) begin
          chk("rr_order", 32'(rsp_id), 32'(exp_ids[fires]));
          chk("rr_rsp_z", 32'(rsp_z), 32'(rr_z[exp_ids[fires]]));
        end
        fires++;
        prev_fire = 1'b1;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("rr_fires", 32'(fires), 32'd6);
    chk("rr_op_count", 32'(op_count), 32'd6);
    chk("rr_idle", 32'(busy), 32'h0);

    // Backpressure: response stalls five cycles with others requesting.
    set_ops(2, 5'b11111, 5'b00000);
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1011;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_z", 32'(rsp_z), 32'h0);
      chk("bp_rsp_id", 32'(rsp_id), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
      chk("bp_op_count_hold", 32'(op_count), 32'd6);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_valid", 32'(rsp_valid), 32'h0);
    chk("bp_release_count", 32'(op_count), 32'd7);
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    req_valid = '0;
    tick();
    chk("bp_count_once", 32'(op_count), 32'd7);
    chk("bp_no_accept", 32'(busy), 32'h0);

    // Reset during EXEC drops the operation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ops(1, 5'b00110, 5'b01100);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("mid_in_exec", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_state_idle", 32'(busy), 32'h0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_op_count", 32'(op_count), 32'h0);
    tick();
    chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 4'b0011;
    #1;
    chk("mid_next_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("mid_next_id", 32'(gate_a), 32'(req_a[4:0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
